frame_dispatcher: RTL and testbench



---
 rtl/frame_dispatcher_pkg.sv | 19 +
 rtl/dispatch_perf_cnt.sv | 24 ++
 rtl/frame_dispatcher.sv | 187 ++++++++++++++++++
 tb/tb_frame_dispatcher.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_dispatcher_pkg.sv
// Shared types and header layout constants for the frame dispatcher.
package frame_dispatcher_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_H0, S_H1, S_H2, S_H3,
    S_F_LO, S_F_HI, S_F_CAP, S_ISSUE,
    S_END, S_FWAIT, S_HALT
  } state_t;

  localparam int HDR_FENCE_OFS  = 0;
  localparam int HDR_MASK_OFS   = 1;
  localparam int HDR_R0_OFS     = 2;
  localparam int INSTR_OFS      = 3;

  localparam int FENCE_WAIT_BIT = 0;
  localparam int FENCE_HALT_BIT = 1;
  localparam int FENCE_LSB      = 6;

endpackage

// File: rtl/dispatch_perf_cnt.sv
// Pair of saturating event counters with synchronous clear.
module dispatch_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc_a,
  input  logic         inc_b,
  output logic [W-1:0] cnt_a,
  output logic [W-1:0] cnt_b
);

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (inc_a && cnt_a != '1) cnt_a <= cnt_a + 1'b1;
      if (inc_b && cnt_b != '1) cnt_b <= cnt_b + 1'b1;
    end
  end

endmodule

// File: rtl/frame_dispatcher.sv
// Walks instruction frames in memory and streams 2-word instructions to the cores.
// Optional perf counters enabled by FRAME_DISPATCHER_PERF_EN.
module frame_dispatcher
  import frame_dispatcher_pkg::*;
#(
  parameter int NUM_CORES   = 16,
  parameter int WORD_W      = 16,
  parameter int FRAME_WORDS = 256,
  parameter int NUM_FRAMES  = 64,
  parameter int CNT_W       = 6,
  parameter int ADDR_W      = $clog2(NUM_FRAMES * FRAME_WORDS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  output logic                          mem_rd_en,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [WORD_W-1:0]             mem_rdata,
  output logic                          instr_valid,
  input  logic                          instr_ready,
  output logic [2*WORD_W-1:0]           instr_data,
  output logic [NUM_CORES-1:0]          exec_mask,
  output logic [NUM_CORES-1:0]          init_r0_vect,
  output logic                          frame_start,
  input  logic [NUM_CORES-1:0]          core_busy,
  output logic [$clog2(NUM_FRAMES)-1:0] frame_idx,
  output logic                          halted
`ifdef FRAME_DISPATCHER_PERF_EN
  ,
  output logic [31:0]                   perf_issued,
  output logic [31:0]                   perf_stall
`endif
);

  localparam int FI_W = $clog2(NUM_FRAMES);

  if (3 + 2 * ((1 << CNT_W) - 1) > FRAME_WORDS) begin : g_bad_cnt_w
    $error("CNT_W too wide: instructions overflow FRAME_WORDS");
  end

  state_t             state;
  logic [1:0]         fence;
  logic [CNT_W-1:0]   cnt;
  logic [ADDR_W-1:0]  ptr;
  logic [WORD_W-1:0]  lo_word;
  logic [NUM_CORES-1:0] rdata_cores;
  logic [FI_W-1:0]    next_frame;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [FI_W-1:0] idx,
                                                input logic [ADDR_W-1:0] ofs);
    return ADDR_W'(idx) * ADDR_W'(FRAME_WORDS) + ofs;
  endfunction

  // Mask/r0 words are LSB-aligned; cores beyond the word width read as zero.
  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core_bit
    if (i < WORD_W) begin : g_map
      assign rdata_cores[i] = mem_rdata[i];
    end else begin : g_pad
      assign rdata_cores[i] = 1'b0;
    end
  end

  assign next_frame = (frame_idx == FI_W'(NUM_FRAMES - 1)) ? '0 : frame_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      mem_rd_en    <= 1'b0;
      mem_addr     <= '0;
      instr_valid  <= 1'b0;
      instr_data   <= '0;
      exec_mask    <= '0;
      init_r0_vect <= '0;
      frame_start  <= 1'b0;
      frame_idx    <= '0;
      halted       <= 1'b0;
      fence        <= '0;
      cnt          <= '0;
      ptr          <= '0;
      lo_word      <= '0;
    end else begin
      // Read strobe is issued on entry to each read state, so data lands in the next one.
      mem_rd_en   <= 1'b0;
      frame_start <= 1'b0;
      case (state)
        S_IDLE, S_HALT: if (start) begin
          frame_idx <= '0;
          halted    <= 1'b0;
          mem_rd_en <= 1'b1;
          mem_addr  <= addr_of('0, ADDR_W'(HDR_FENCE_OFS));
          state     <= S_H0;
        end
        S_H0: begin
          mem_rd_en <= 1'b1;
          mem_addr  <= addr_of(frame_idx, ADDR_W'(HDR_MASK_OFS));
          state     <= S_H1;
        end
        S_H1: begin
          fence     <= mem_rdata[FENCE_LSB +: 2];
          cnt       <= mem_rdata[CNT_W-1:0];
          mem_rd_en <= 1'b1;
          mem_addr  <= addr_of(frame_idx, ADDR_W'(HDR_R0_OFS));
          state     <= S_H2;
        end
        S_H2: begin
          exec_mask <= rdata_cores;
          state     <= S_H3;
        end
        S_H3: begin
          init_r0_vect <= rdata_cores;
          frame_start  <= 1'b1;
          ptr          <= ADDR_W'(INSTR_OFS);
          if (cnt == '0) state <= S_END;
          else begin
            mem_rd_en <= 1'b1;
            mem_addr  <= addr_of(frame_idx, ADDR_W'(INSTR_OFS));
            state     <= S_F_LO;
          end
        end
        S_F_LO: begin
          mem_rd_en <= 1'b1;
          mem_addr  <= addr_of(frame_idx, ptr + ADDR_W'(1));
          state     <= S_F_HI;
        end
        S_F_HI: begin
          lo_word <= mem_rdata;
          state   <= S_F_CAP;
        end
        S_F_CAP: begin
          instr_data  <= {mem_rdata, lo_word};
          instr_valid <= 1'b1;
          state       <= S_ISSUE;
        end
        S_ISSUE: if (instr_ready) begin
          instr_valid <= 1'b0;
          cnt         <= cnt - 1'b1;
          ptr         <= ptr + ADDR_W'(2);
          if (cnt == CNT_W'(1)) state <= S_END;
          else begin
            mem_rd_en <= 1'b1;
            mem_addr  <= addr_of(frame_idx, ptr + ADDR_W'(2));
            state     <= S_F_LO;
          end
        end
        S_END: begin
          if (fence[FENCE_HALT_BIT]) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else if (fence[FENCE_WAIT_BIT]) begin
            state <= S_FWAIT;
          end else begin
            frame_idx <= next_frame;
            mem_rd_en <= 1'b1;
            mem_addr  <= addr_of(next_frame, ADDR_W'(HDR_FENCE_OFS));
            state     <= S_H0;
          end
        end
        S_FWAIT: if ((core_busy & exec_mask) == '0) begin
          frame_idx <= next_frame;
          mem_rd_en <= 1'b1;
          mem_addr  <= addr_of(next_frame, ADDR_W'(HDR_FENCE_OFS));
          state     <= S_H0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FRAME_DISPATCHER_PERF_EN
  logic perf_clr, perf_hs, perf_stl;

  assign perf_clr = start && (state == S_IDLE || state == S_HALT);
  assign perf_hs  = (state == S_ISSUE) && instr_ready;
  assign perf_stl = ((state == S_ISSUE) && !instr_ready) || (state == S_FWAIT);

  dispatch_perf_cnt #(.W(32)) u_perf (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (perf_clr),
    .inc_a (perf_hs),
    .inc_b (perf_stl),
    .cnt_a (perf_issued),
    .cnt_b (perf_stall)
  );
`endif

endmodule

// File: tb/tb_frame_dispatcher.sv
// Directed + randomized bench for frame_dispatcher against a program-walking reference model.
module tb_frame_dispatcher;

  localparam int NC = 16, WW = 16, FW = 256, NF = 4, CW = 6, AW = 10, FIW = 2;

  logic clk = 1'b0;
  logic rst_n, start, mem_rd_en, instr_valid, instr_ready, frame_start, halted;
  logic [AW-1:0]   mem_addr;
  logic [WW-1:0]   mem_rdata;
  logic [2*WW-1:0] instr_data;
  logic [NC-1:0]   exec_mask, init_r0_vect, core_busy;
  logic [FIW-1:0]  frame_idx;
`ifdef FRAME_DISPATCHER_PERF_EN
  logic [31:0] perf_issued, perf_stall;
`endif

  always #5 clk = ~clk;

  frame_dispatcher #(
    .NUM_CORES(NC), .WORD_W(WW), .FRAME_WORDS(FW), .NUM_FRAMES(NF), .CNT_W(CW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .exec_mask(exec_mask), .init_r0_vect(init_r0_vect), .frame_start(frame_start),
    .core_busy(core_busy), .frame_idx(frame_idx), .halted(halted)
`ifdef FRAME_DISPATCHER_PERF_EN
    , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
  );

  // Synchronous-read frame memory
  logic [WW-1:0] mem [NF*FW];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Ready source: random in mode 1, otherwise follows rdy_force
  int   rdy_mode = 0;
  logic rdy_force = 1'b1;
  initial begin
    instr_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      instr_ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : rdy_force;
    end
  end

  // Passive monitor, samples on the falling edge
  logic [2*WW-1:0] hs_q[$];
  int hs_cyc[$], vr_cyc[$], fs_cyc[$], fs_q[$], rd_q[$];
  logic [NC-1:0] fs_mask[$], fs_r0[$];
  int stab_err = 0;
  logic pv = 1'b0, pr = 1'b0;
  logic [2*WW-1:0] pd = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (instr_valid && instr_ready) begin hs_q.push_back(instr_data); hs_cyc.push_back(cyc); end
      if (instr_valid && !pv) vr_cyc.push_back(cyc);
      if (frame_start) begin
        fs_q.push_back(int'(frame_idx)); fs_cyc.push_back(cyc);
        fs_mask.push_back(exec_mask); fs_r0.push_back(init_r0_vect);
      end
      if (mem_rd_en) rd_q.push_back(int'(mem_addr));
      if (pv && !pr && (!instr_valid || instr_data !== pd)) stab_err <= stab_err + 1;
    end
    pv <= rst_n && instr_valid;
    pr <= instr_ready;
    pd <= instr_data;
  end

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    hs_q.delete(); hs_cyc.delete(); vr_cyc.delete(); fs_cyc.delete();
    fs_q.delete(); rd_q.delete(); fs_mask.delete(); fs_r0.delete();
  endtask

  task automatic put_frame(input int f, input logic [1:0] fence, input int cnt,
                           input logic [15:0] mask, input logic [15:0] r0);
    mem[f*FW + 0] = {8'h00, fence, 6'(cnt)};
    mem[f*FW + 1] = mask;
    mem[f*FW + 2] = r0;
  endtask

  task automatic put_instr(input int f, input int i, input logic [15:0] lo, input logic [15:0] hi);
    mem[f*FW + 3 + 2*i] = lo;
    mem[f*FW + 4 + 2*i] = hi;
  endtask

  // Reference: walk the program from frame 0 until a halt fence
  logic [2*WW-1:0] exp_hs[$];
  int exp_fs[$];
  task automatic build_model(input int max_frames);
    int f;
    logic [WW-1:0] h;
    exp_hs.delete(); exp_fs.delete();
    f = 0;
    for (int n = 0; n < max_frames; n++) begin
      h = mem[f*FW];
      exp_fs.push_back(f);
      for (int i = 0; i < int'(h[CW-1:0]); i++)
        exp_hs.push_back({mem[f*FW + 4 + 2*i], mem[f*FW + 3 + 2*i]});
      if (h[7]) break;
      f = (f + 1) % NF;
    end
  endtask

  task automatic check_reset_outputs(input string p);
    chk({p, "_rd_en"}, mem_rd_en, 0);
    chk({p, "_addr"}, mem_addr, 0);
    chk({p, "_valid"}, instr_valid, 0);
    chk({p, "_data"}, instr_data, 0);
    chk({p, "_mask"}, exec_mask, 0);
    chk({p, "_r0"}, init_r0_vect, 0);
    chk({p, "_fstart"}, frame_start, 0);
    chk({p, "_fidx"}, frame_idx, 0);
    chk({p, "_halted"}, halted, 0);
  endtask

  int st_cyc;
  task automatic pulse_start();
    start = 1'b1;
    st_cyc = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic run_until_halt(input string tag, input int budget);
    for (int i = 0; i < budget && !halted; i++) tick();
    chk({tag, "_halt_reached"}, halted, 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; core_busy = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    clear_mon();
  endtask

  // Two-instruction frame 0, then an empty halting frame 1
  task automatic scen_basic(input string tag);
    int exp_rd[10] = '{0, 1, 2, 3, 4, 5, 6, 256, 257, 258};
    put_frame(0, 2'b00, 2, 16'h00FF, 16'h0F0F);
    put_instr(0, 0, 16'h1111, 16'h2222);
    put_instr(0, 1, 16'h3333, 16'h4444);
    put_frame(1, 2'b10, 0, 16'h1234, 16'h5678);
    rdy_mode = 0; rdy_force = 1'b1;
    tick();
    clear_mon();
    pulse_start();
    run_until_halt(tag, 200);
    // latencies counted from the clock edge that samples the cause
    chk({tag, "_start_to_fs"}, fs_cyc[0] - st_cyc - 1, 4);
    chk({tag, "_fs_to_vld"}, vr_cyc[0] - fs_cyc[0], 3);
    chk({tag, "_hs_to_vld"}, vr_cyc[1] - hs_cyc[0] - 1, 3);
    chk({tag, "_hs_count"}, hs_q.size(), 2);
    chk({tag, "_instr0"}, hs_q[0], 32'h2222_1111);
    chk({tag, "_instr1"}, hs_q[1], 32'h4444_3333);
    chk({tag, "_vld_count"}, vr_cyc.size(), 2);
    chk({tag, "_fs_frames"}, {fs_q[0], fs_q[1]}, {32'd0, 32'd1});
    chk({tag, "_mask0"}, fs_mask[0], 16'h00FF);
    chk({tag, "_r00"}, fs_r0[0], 16'h0F0F);
    chk({tag, "_rd_count"}, rd_q.size(), 10);
    for (int i = 0; i < 10; i++) chk($sformatf("%s_rd%0d", tag, i), rd_q[i], exp_rd[i]);
  endtask

  logic [2*WW-1:0] d0;
  int n0, tot;
  initial begin
    rst_n = 1'b0; start = 1'b0; core_busy = '0;
    for (int i = 0; i < NF*FW; i++) mem[i] = '0;
    tick(); tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    scen_basic("basic");
    pulse_start();
    chk("restart_fidx", frame_idx, 0);
    chk("restart_halted", halted, 0);
    chk("restart_rd", {mem_rd_en, 6'(mem_addr)}, {1'b1, 6'd0});
    run_until_halt("restart", 200);

    // Empty halting frame: no instructions ever offered
    do_reset();
    put_frame(0, 2'b10, 0, 16'hAAAA, 16'h5555);
    pulse_start();
    run_until_halt("cnt0", 50);
    chk("cnt0_no_valid", vr_cyc.size(), 0);
    chk("cnt0_fs", fs_q.size(), 1);
    pulse_start();
    chk("cnt0_restart_halted", halted, 0);

    // Backpressure: five stalled cycles, one handshake per instruction
    do_reset();
    put_frame(0, 2'b10, 2, 16'h00FF, 16'h0000);
    put_instr(0, 0, 16'($urandom), 16'($urandom));
    put_instr(0, 1, 16'($urandom), 16'($urandom));
    rdy_force = 1'b0;
    tick();
    pulse_start();
    for (int i = 0; i < 30 && !instr_valid; i++) tick();
    chk("stall_valid_seen", instr_valid, 1);
    d0 = instr_data;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stall_hold%0d", i), {instr_valid, instr_data}, {1'b1, d0});
    end
    chk("stall_no_hs", hs_q.size(), 0);
    rdy_force = 1'b1;
    run_until_halt("stall", 60);
    build_model(16);
    chk("stall_hs_count", hs_q.size(), 2);
    chk("stall_instr0", hs_q[0], exp_hs[0]);
    chk("stall_instr1", hs_q[1], exp_hs[1]);

    // Wait fence: busy bits outside the mask must be ignored
    do_reset();
    put_frame(0, 2'b01, 1, 16'h000F, 16'h0001);
    put_instr(0, 0, 16'hBEEF, 16'hCAFE);
    put_frame(1, 2'b10, 0, 16'hFFFF, 16'h0000);
    core_busy = 16'hF0F3;
    pulse_start();
    for (int i = 0; i < 40 && hs_q.size() == 0; i++) tick();
    chk("fwait_hs", hs_q.size(), 1);
    tick();
    n0 = rd_q.size();
    for (int i = 0; i < 6; i++) tick();
    chk("fwait_no_read", rd_q.size(), n0);
    chk("fwait_fidx_hold", frame_idx, 0);
    core_busy = 16'hF0F0;
    tick();
    chk("fwait_release", {mem_rd_en, mem_addr, frame_idx}, {1'b1, 10'd256, 2'd1});
    run_until_halt("fwait", 50);

    // Frame index wrap with no fences, random ready
    do_reset();
    for (int f = 0; f < NF; f++) begin
      put_frame(f, 2'b00, (f == 0) ? 1 : int'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
      for (int i = 0; i < 3; i++) put_instr(f, i, 16'($urandom), 16'($urandom));
    end
    rdy_mode = 1;
    pulse_start();
    for (int i = 0; i < 2000 && fs_q.size() < 5; i++) tick();
    chk("wrap_fs_count", fs_q.size() >= 5, 1);
    for (int i = 0; i < 5; i++) chk($sformatf("wrap_fidx%0d", i), fs_q[i], i % NF);
    build_model(NF);
    tot = exp_hs.size();
    for (int i = 0; i < tot; i++) chk($sformatf("wrap_instr%0d", i), hs_q[i], exp_hs[i]);

    // Reset in the middle of ISSUE, then a clean rerun
    rdy_mode = 0; rdy_force = 1'b0;
    for (int i = 0; i < 200 && !instr_valid; i++) tick();
    chk("midrst_valid_seen", instr_valid, 1);
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midrst");
    rst_n = 1'b1;
    tick();
    scen_basic("after_rst");

    // Randomized programs against the reference walk
    for (int it = 0; it < 3; it++) begin
      do_reset();
      for (int f = 0; f < NF; f++) begin
        put_frame(f, (f == NF-1) ? 2'b10 : 2'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                  16'($urandom), 16'($urandom));
        for (int i = 0; i < 5; i++) put_instr(f, i, 16'($urandom), 16'($urandom));
      end
      rdy_mode = 1;
      pulse_start();
      run_until_halt($sformatf("rnd%0d", it), 3000);
      build_model(16);
      chk($sformatf("rnd%0d_hs_count", it), hs_q.size(), exp_hs.size());
      chk($sformatf("rnd%0d_fs_count", it), fs_q.size(), exp_fs.size());
      for (int i = 0; i < exp_hs.size(); i++)
        chk($sformatf("rnd%0d_instr%0d", it, i), hs_q[i], exp_hs[i]);
      for (int i = 0; i < exp_fs.size(); i++) begin
        chk($sformatf("rnd%0d_fidx%0d", it, i), fs_q[i], exp_fs[i]);
        chk($sformatf("rnd%0d_mask%0d", it, i), fs_mask[i], mem[exp_fs[i]*FW + 1]);
        chk($sformatf("rnd%0d_r0_%0d", it, i), fs_r0[i], mem[exp_fs[i]*FW + 2]);
      end
    end
    rdy_mode = 0;

    chk("data_stable_under_stall", stab_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
